instr_mem_loader: RTL and testbench

Writable instruction store with a boot-time byte-stream loader. It holds a byte-addressed instruction memory and fills it from an 8-bit valid/ready stream, which replaces load-from-file initialisation. Fetch reads it combinationally, assembling 32-bit words little-endian. It sits between the external boot/download source and the processor fetch stage; `busy` holds the CPU in reset while a program is being loaded.

---
 rtl/instr_mem_pkg.sv | 14 +
 rtl/instr_byte_ram.sv | 33 +++
 rtl/instr_mem_loader.sv | 132 +++++++++++++
 tb/tb_instr_mem_loader.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_pkg.sv
// Shared types and default geometry for the instruction store and its boot loader.
package instr_mem_pkg;

    localparam int unsigned DEFAULT_DEPTH = 64;
    localparam int unsigned DEFAULT_AW    = 6;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CHECK,
        DONE
    } loader_state_t;

endpackage

// File: rtl/instr_byte_ram.sv
// Byte-wide instruction storage: one synchronous write port and a combinational
// 4-byte little-endian read port that wraps modulo DEPTH.
module instr_byte_ram
    import instr_mem_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned AW    = DEFAULT_AW
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [7:0] mem_q [DEPTH];

    // No reset: contents survive rst so a partial load stays visible.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata_o = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            rdata_o[8*i +: 8] = mem_q[raddr_i + AW'(i)];
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Writable instruction store filled from an 8-bit valid/ready boot stream,
// terminated by an XOR checksum byte; fetch reads 32-bit words combinationally.
module instr_mem_loader
    import instr_mem_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned AW    = DEFAULT_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW:0]   len,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   Raddr,
    output logic [31:0]   instr,
    output logic          busy,
    output logic          done,
    output logic          err
);

    loader_state_t state_q, state_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW:0]   len_q, len_d;
    logic [7:0]    csum_q, csum_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          len_ok;
    logic          last_byte;
    logic          we;
    logic          unused_raddr_hi;

    assign len_ok    = (len != '0) && (len <= (AW+1)'(DEPTH));
    assign last_byte = ({1'b0, cnt_q} == (len_q - (AW+1)'(1)));

    assign in_ready = (state_q == LOAD) || (state_q == CHECK);
    assign busy     = in_ready;
    assign done     = done_q;
    assign err      = err_q;

    // rst has priority over a byte arriving on the same edge.
    assign we = (state_q == LOAD) && in_valid && !rst;

    assign unused_raddr_hi = ^Raddr[31:AW];

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        csum_d  = csum_q;
        done_d  = done_q;
        err_d   = err_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    if (len_ok) begin
                        state_d = LOAD;
                        wptr_d  = '0;
                        cnt_d   = '0;
                        csum_d  = '0;
                        len_d   = len;
                        done_d  = 1'b0;
                        err_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b0;
                        err_d   = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (in_valid) begin
                    csum_d = csum_q ^ in_data;
                    wptr_d = wptr_q + AW'(1);
                    cnt_d  = cnt_q + AW'(1);
                    if (last_byte) begin
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                if (in_valid) begin
                    if (in_data == csum_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wptr_q  <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            csum_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            csum_q  <= csum_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    instr_byte_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (we),
        .waddr_i (wptr_q),
        .wdata_i (in_data),
        .raddr_i (Raddr[AW-1:0]),
        .rdata_o (instr)
    );

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: transaction-level model checked every
// cycle, plus literal expectations for the documented scenarios.
module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [6:0]  len = '0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] Raddr = '0;
    logic [31:0] instr;
    logic        busy;
    logic        done;
    logic        err;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;
    bit auto_raddr = 1'b1;

    // Model: a load is "active" from an accepted good start until the
    // checksum byte; left counts program bytes still expected.
    logic [7:0] m_mem [64];
    bit         m_known [64];
    bit         m_active = 1'b0;
    bit         m_done = 1'b0;
    bit         m_err = 1'b0;
    int         m_left = 0;
    int         m_wp = 0;
    logic [7:0] m_x = '0;

    instr_mem_loader #(.DEPTH(64), .AW(6)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .len      (len),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .Raddr    (Raddr),
        .instr    (instr),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_active = 1'b0;
            m_done   = 1'b0;
            m_err    = 1'b0;
        end else if (m_active) begin
            if (in_valid) begin
                if (m_left > 0) begin
                    m_mem[m_wp]   = in_data;
                    m_known[m_wp] = 1'b1;
                    m_x           = m_x ^ in_data;
                    m_wp          = (m_wp + 1) % 64;
                    m_left--;
                end else begin
                    m_active = 1'b0;
                    if (in_data == m_x) m_done = 1'b1;
                    else                m_err  = 1'b1;
                end
            end
        end else if (start) begin
            if (len >= 1 && len <= 64) begin
                m_active = 1'b1;
                m_left   = int'(len);
                m_wp     = 0;
                m_x      = '0;
                m_done   = 1'b0;
                m_err    = 1'b0;
            end else begin
                m_err  = 1'b1;
                m_done = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            int a;
            bit all_known;
            logic [31:0] w;
            chk("busy", busy, m_active);
            chk("in_ready", in_ready, m_active);
            chk("done", done, m_done);
            chk("err", err, m_err);
            a = int'(Raddr[5:0]);
            all_known = 1'b1;
            w = '0;
            for (int k = 0; k < 4; k++) begin
                all_known &= m_known[(a + k) % 64];
                w[8*k +: 8] = m_mem[(a + k) % 64];
            end
            if (all_known) chk("instr_model", instr, w);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (auto_raddr) Raddr = $urandom;
    endtask

    task automatic do_start(input int l);
        start = 1'b1;
        len   = 7'(l);
        step();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        for (int g = 0; g < gap; g++) step();
        in_valid = 1'b1;
        in_data  = b;
        step();
        in_valid = 1'b0;
    endtask

    task automatic read_at(input logic [31:0] a, input logic [31:0] exp, input string name);
        auto_raddr = 1'b0;
        Raddr = a;
        #1;
        chk(name, instr, exp);
        auto_raddr = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            m_mem[i] = '0;
            m_known[i] = 1'b0;
        end
        step();
        step();
        rst = 1'b0;
        cmp_en = 1'b1;
        chk("reset_busy", busy, 0);
        chk("reset_ready", in_ready, 0);
        chk("reset_done", done, 0);
        chk("reset_err", err, 0);

        // Good load
        do_start(4);
        chk("good_ready_after_start", in_ready, 1);
        send_byte(8'h78, 0);
        send_byte(8'h56, 0);
        send_byte(8'h34, 0);
        send_byte(8'h12, 0);
        chk("good_before_csum_done", done, 0);
        send_byte(8'h08, 0);
        chk("good_done", done, 1);
        chk("good_err", err, 0);
        chk("good_busy", busy, 0);
        read_at(32'h0, 32'h12345678, "good_instr0");

        // Bad checksum
        do_start(4);
        send_byte(8'h78, 0);
        send_byte(8'h56, 0);
        send_byte(8'h34, 0);
        send_byte(8'h12, 0);
        send_byte(8'h09, 0);
        chk("badcs_err", err, 1);
        chk("badcs_done", done, 0);
        chk("badcs_busy", busy, 0);
        read_at(32'h0, 32'h12345678, "badcs_instr0");

        // Illegal lengths
        do_start(0);
        chk("len0_err", err, 1);
        chk("len0_ready", in_ready, 0);
        step();
        chk("len0_ready_later", in_ready, 0);
        do_start(65);
        chk("len65_err", err, 1);
        chk("len65_ready", in_ready, 0);

        // Full 64-byte load, wrap-around and misaligned reads
        do_start(64);
        for (int i = 0; i < 64; i++) send_byte(8'(i), 0);
        send_byte(8'h00, 0);
        chk("wrap_done", done, 1);
        chk("wrap_err", err, 0);
        read_at(32'd62, 32'h01003F3E, "wrap_instr62");
        read_at(32'h101, 32'h04030201, "wrap_instr101");

        // Backpressure, with a start pulse that must be ignored mid-load
        do_start(3);
        send_byte(8'hAA, 1);
        start = 1'b1;
        len   = 7'd0;
        step();
        start = 1'b0;
        chk("ignored_start_err", err, 0);
        chk("ignored_start_busy", busy, 1);
        send_byte(8'hBB, 1);
        send_byte(8'hCC, 1);
        chk("bp_no_done_yet", done, 0);
        send_byte(8'hDD, 2);
        chk("bp_done", done, 1);
        read_at(32'h0, 32'h03CCBBAA, "bp_instr0");

        // Reset mid-load, then restart at address 0
        do_start(4);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstmid_busy", busy, 0);
        chk("rstmid_ready", in_ready, 0);
        chk("rstmid_done", done, 0);
        read_at(32'h0, 32'h03CC2211, "rstmid_instr0");
        do_start(2);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        send_byte(8'h33, 0);
        chk("restart_done", done, 1);
        read_at(32'h0, 32'h03CC6655, "restart_instr0");

        // rst and start together: rst wins
        rst   = 1'b1;
        start = 1'b1;
        len   = 7'd4;
        step();
        rst   = 1'b0;
        start = 1'b0;
        chk("rst_start_busy", busy, 0);
        chk("rst_start_done", done, 0);
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
